// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one byte-level UART transmitter among NUM_REQ sources.
// A grant lasts until the requester's last byte, MAX_BURST bytes, or IDLE_TIMEOUT idle cycles.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          grant_active
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} stateT;

  stateT                 state, stateD;
  logic [GW-1:0]         grantIdD, pickId;
  logic                  grantActiveD, txStartD;
  logic [DATA_WIDTH-1:0] txDataD, selData;
  logic [BW-1:0]         burstCnt, burstCntD;
  logic [IW-1:0]         idleCnt, idleCntD;
  logic                  lastQ, lastD;
  logic                  selValid, selLast, sendOk, accept;
  logic [GW-1:0]         cand;

  // Granted requester's byte and the handshake toward it
  always_comb begin
    selValid  = 1'b0;
    selLast   = 1'b0;
    selData   = '0;
    sendOk    = (state == SEND) && !tx_busy;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == grant_id) begin
        selValid     = req_valid[i];
        selLast      = req_last[i];
        selData      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = sendOk;
      end
    end
    accept = sendOk && selValid;
  end

  // Round-robin pick: lowest offset from the last grant wins (loop runs high offset to low)
  always_comb begin
    pickId = grant_id;
    cand   = grant_id;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = GW'((int'(grant_id) + i) % NUM_REQ);
      if (req_valid[cand]) pickId = cand;
    end
  end

  always_comb begin
    stateD       = state;
    grantIdD     = grant_id;
    grantActiveD = grant_active;
    txStartD     = 1'b0;
    txDataD      = tx_data;
    burstCntD    = burstCnt;
    idleCntD     = idleCnt;
    lastD        = lastQ;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grantIdD     = pickId;
          grantActiveD = 1'b1;
          burstCntD    = '0;
          idleCntD     = '0;
          stateD       = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          txDataD   = selData;
          txStartD  = 1'b1;
          lastD     = selLast;
          burstCntD = burstCnt + BW'(1);
          idleCntD  = '0;
          stateD    = WAIT_ACK;
        end else if (!selValid) begin
          if (idleCnt == IDLE_LAST) begin
            grantActiveD = 1'b0;
            stateD       = IDLE;
          end else begin
            idleCntD = idleCnt + IW'(1);
          end
        end
      end
      WAIT_ACK: begin
        if (tx_busy) stateD = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          // last byte and burst cap reached together still give one release
          if (lastQ || burstCnt == BURST_MAX) begin
            grantActiveD = 1'b0;
            stateD       = IDLE;
          end else begin
            stateD = SEND;
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant_id     <= GW'(NUM_REQ - 1);
      grant_active <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      burstCnt     <= '0;
      idleCnt      <= '0;
      lastQ        <= 1'b0;
    end else begin
      state        <= stateD;
      grant_id     <= grantIdD;
      grant_active <= grantActiveD;
      tx_start     <= txStartD;
      tx_data      <= txDataD;
      burstCnt     <= burstCntD;
      idleCnt      <= idleCntD;
      lastQ        <= lastD;
    end
  end

endmodule
